// File: rtl/rop_ba_mem_rsp_if.sv
// COP memory port bundle between rop_ba_cop (master) and rop_ba_mem_rsp (slave).
interface rop_ba_mem_rsp_if;
   logic        cop_mem_cen;
   logic        cop_mem_wen;
   logic [3:0]  cop_mem_ben;
   logic [31:0] cop_mem_wdata;
   logic [31:0] cop_mem_addr;
   logic        cop_mem_stall;
   logic        cop_mem_error;
   logic [31:0] cop_mem_rdata;

   modport master (
      output cop_mem_cen, cop_mem_wen, cop_mem_ben, cop_mem_wdata, cop_mem_addr,
      input  cop_mem_stall, cop_mem_error, cop_mem_rdata
   );

   modport slave (
      input  cop_mem_cen, cop_mem_wen, cop_mem_ben, cop_mem_wdata, cop_mem_addr,
      output cop_mem_stall, cop_mem_error, cop_mem_rdata
   );
endinterface

// File: rtl/rop_ba_mem_rsp.sv
// Word-addressed SRAM responder for the COP memory port with programmable wait states.
// Optional random extra stall (0..3 cycles from a 4-bit LFSR) under ROP_BA_MEM_RSP_RANDSTALL_EN.
module rop_ba_mem_rsp #(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              resetn,
   rop_ba_mem_rsp_if.slave   mem
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic              wen_q, wen_d;
   logic [3:0]        ben_q, ben_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              fault_q, fault_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              error_q, error_d;
   logic [31:0]       mem_q [DEPTH];

   logic [31:0]       off;
   logic [IDX_W-1:0]  live_idx;
   logic              live_fault;
   logic [4:0]        extra;
   logic              mem_we;

   // Full-width offset compare so an address just past the array never aliases onto word 0.
   always_comb begin
      off        = mem.cop_mem_addr - BASE_ADDR;
      live_idx   = off[IDX_W+1:2];
      live_fault = (mem.cop_mem_addr < BASE_ADDR) ||
                   ({32'd0, off} >= (64'(DEPTH) << 2));
   end

`ifdef ROP_BA_MEM_RSP_RANDSTALL_EN
   logic [3:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (state_q == S_IDLE && mem.cop_mem_cen)
         lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) lfsr_q <= 4'b1001;
      else         lfsr_q <= lfsr_d;
   end

   assign extra = {3'b000, lfsr_q[1:0]};
`else
   assign extra = 5'd0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wen_d   = wen_q;
      ben_d   = ben_q;
      wdata_d = wdata_q;
      idx_d   = idx_q;
      fault_d = fault_q;
      rdata_d = rdata_q;
      error_d = error_q;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem.cop_mem_cen) begin
               wen_d   = mem.cop_mem_wen;
               ben_d   = mem.cop_mem_ben;
               wdata_d = mem.cop_mem_wdata;
               idx_d   = live_idx;
               fault_d = live_fault;
               cnt_d   = 5'(WAIT_CYCLES) + extra;
               if (cnt_d == 5'd0) begin
                  state_d = S_RESP;
                  rdata_d = live_fault ? 32'd0 : mem_q[live_idx];
                  error_d = live_fault;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!mem.cop_mem_cen) begin
               state_d = S_IDLE;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  state_d = S_RESP;
                  rdata_d = fault_q ? 32'd0 : mem_q[idx_q];
                  error_d = fault_q;
               end
            end
         end
         S_RESP: begin
            // Writes land only on the completing edge; a dropped cen aborts without writing.
            state_d = S_IDLE;
            mem_we  = mem.cop_mem_cen && wen_q && !fault_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         wen_q   <= 1'b0;
         ben_q   <= 4'd0;
         wdata_q <= 32'd0;
         idx_q   <= '0;
         fault_q <= 1'b0;
         rdata_q <= 32'd0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         ben_q   <= ben_d;
         wdata_q <= wdata_d;
         idx_q   <= idx_d;
         fault_q <= fault_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end

   // Array contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (ben_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign mem.cop_mem_stall = mem.cop_mem_cen && (state_q != S_RESP);
   assign mem.cop_mem_rdata = rdata_q;
   assign mem.cop_mem_error = error_q;

endmodule

// File: tb/tb_rop_ba_mem_rsp.sv
// Directed bench for rop_ba_mem_rsp: three instances (no wait / 3 waits with offset base / 2 waits).
module tb_rop_ba_mem_rsp;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, rst2_n;
   logic        cen [3];
   logic        wen [3];
   logic [3:0]  ben [3];
   logic [31:0] wdata [3];
   logic [31:0] addr [3];
   logic        stall [3];
   logic        err [3];
   logic [31:0] rdata [3];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   rop_ba_mem_rsp_if bus0 ();
   rop_ba_mem_rsp_if bus1 ();
   rop_ba_mem_rsp_if bus2 ();

   assign bus0.cop_mem_cen = cen[0];   assign bus1.cop_mem_cen = cen[1];   assign bus2.cop_mem_cen = cen[2];
   assign bus0.cop_mem_wen = wen[0];   assign bus1.cop_mem_wen = wen[1];   assign bus2.cop_mem_wen = wen[2];
   assign bus0.cop_mem_ben = ben[0];   assign bus1.cop_mem_ben = ben[1];   assign bus2.cop_mem_ben = ben[2];
   assign bus0.cop_mem_wdata = wdata[0]; assign bus1.cop_mem_wdata = wdata[1]; assign bus2.cop_mem_wdata = wdata[2];
   assign bus0.cop_mem_addr = addr[0]; assign bus1.cop_mem_addr = addr[1]; assign bus2.cop_mem_addr = addr[2];
   assign stall[0] = bus0.cop_mem_stall; assign stall[1] = bus1.cop_mem_stall; assign stall[2] = bus2.cop_mem_stall;
   assign err[0]   = bus0.cop_mem_error; assign err[1]   = bus1.cop_mem_error; assign err[2]   = bus2.cop_mem_error;
   assign rdata[0] = bus0.cop_mem_rdata; assign rdata[1] = bus1.cop_mem_rdata; assign rdata[2] = bus2.cop_mem_rdata;

   rop_ba_mem_rsp #(.DEPTH(64), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) u0 (.clk(clk), .resetn(rst_n),  .mem(bus0));
   rop_ba_mem_rsp #(.DEPTH(64), .BASE_ADDR(32'h0000_0100), .WAIT_CYCLES(3)) u1 (.clk(clk), .resetn(rst_n),  .mem(bus1));
   rop_ba_mem_rsp #(.DEPTH(64), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(2)) u2 (.clk(clk), .resetn(rst2_n), .mem(bus2));

   // Issue one request on instance s and run it to completion; ns = stalled negedges seen.
   task automatic xfer(input int s, input logic w, input logic [3:0] b, input logic [31:0] d,
                       input logic [31:0] a, output logic [31:0] rd, output logic er, output int ns);
      @(negedge clk);
      cen[s] = 1'b1; wen[s] = w; ben[s] = b; wdata[s] = d; addr[s] = a;
      ns = 0;
      #1;
      while (stall[s] === 1'b1 && ns < 40) begin
         ns++;
         @(negedge clk);
         #1;
      end
      rd = rdata[s];
      er = err[s];
   endtask

   task automatic release_bus(input int s);
      @(negedge clk);
      cen[s] = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; rst2_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cen[i] = 1'b0; wen[i] = 1'b0; ben[i] = 4'h0; wdata[i] = 32'h0; addr[i] = 32'h0;
      end
      repeat (2) @(negedge clk);
      #1;
      n_tests++; if (stall[0] !== 1'b0) begin n_fail++; $display("FAIL rst_stall_idle: got %b exp 0", stall[0]); end
      cen[0] = 1'b1;
      #1;
      n_tests++; if (stall[0] !== 1'b1) begin n_fail++; $display("FAIL rst_stall_follows_cen: got %b exp 1", stall[0]); end
      n_tests++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 00000000", rdata[0]); end
      n_tests++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b exp 0", err[0]); end
      cen[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; rst2_n = 1'b1;
   endtask

   task automatic test_write_read;
      logic [31:0] rd; logic er; int ns;
      xfer(0, 1'b1, 4'hF, 32'hDEADBEEF, 32'h10, rd, er, ns);
      n_tests++; if (ns !== 1) begin n_fail++; $display("FAIL wr_stall_cycles: got %0d exp 1", ns); end
      n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_error: got %b exp 0", er); end
      xfer(0, 1'b0, 4'h0, 32'h0, 32'h10, rd, er, ns);
      n_tests++; if (ns !== 1) begin n_fail++; $display("FAIL rd_stall_cycles: got %0d exp 1", ns); end
      n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h exp deadbeef", rd); end
      n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_error: got %b exp 0", er); end
      release_bus(0);
   endtask

   task automatic test_byte_lanes;
      logic [31:0] rd; logic er; int ns;
      xfer(0, 1'b1, 4'hF, 32'h11223344, 32'h20, rd, er, ns);
      xfer(0, 1'b1, 4'h2, 32'h0000AB00, 32'h20, rd, er, ns);
      xfer(0, 1'b0, 4'h0, 32'h0, 32'h20, rd, er, ns);
      n_tests++; if (rd !== 32'h1122AB44) begin n_fail++; $display("FAIL lane_merge: got %h exp 1122ab44", rd); end
      xfer(0, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h20, rd, er, ns);
      n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL ben0_error: got %b exp 0", er); end
      xfer(0, 1'b0, 4'h0, 32'h0, 32'h23, rd, er, ns);
      n_tests++; if (rd !== 32'h1122AB44) begin n_fail++; $display("FAIL ben0_unchanged: got %h exp 1122ab44", rd); end
      release_bus(0);
   endtask

   task automatic test_out_of_range;
      logic [31:0] rd; logic er; int ns;
      xfer(0, 1'b1, 4'hF, 32'hA5A5A5A5, 32'h00, rd, er, ns);
      xfer(0, 1'b1, 4'hF, 32'hCAFEF00D, 32'hFC, rd, er, ns);
      xfer(0, 1'b0, 4'h0, 32'h0, 32'hFC, rd, er, ns);
      n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL last_word: got %h exp cafef00d", rd); end
      xfer(0, 1'b0, 4'h0, 32'h0, 32'h100, rd, er, ns);
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_rd_error: got %b exp 1", er); end
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h exp 00000000", rd); end
      xfer(0, 1'b1, 4'hF, 32'h12345678, 32'h100, rd, er, ns);
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_wr_error: got %b exp 1", er); end
      xfer(0, 1'b0, 4'h0, 32'h0, 32'hFC, rd, er, ns);
      n_tests++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin n_fail++; $display("FAIL oor_last_kept: got %h/%b exp cafef00d/0", rd, er); end
      xfer(0, 1'b0, 4'h0, 32'h0, 32'h00, rd, er, ns);
      n_tests++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL oor_no_alias: got %h exp a5a5a5a5", rd); end
      release_bus(0);
   endtask

   task automatic test_wait_states;
      logic [31:0] rd; logic er; int ns;
      xfer(1, 1'b1, 4'hF, 32'h0BADF00D, 32'h100, rd, er, ns);
      n_tests++; if (ns !== 4) begin n_fail++; $display("FAIL ws_wr_stall: got %0d exp 4", ns); end
      xfer(1, 1'b0, 4'h0, 32'h0, 32'h100, rd, er, ns);
      n_tests++; if (ns !== 4) begin n_fail++; $display("FAIL ws_rd_stall: got %0d exp 4", ns); end
      n_tests++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin n_fail++; $display("FAIL ws_rd_data: got %h/%b exp 0badf00d/0", rd, er); end
      xfer(1, 1'b0, 4'h0, 32'h0, 32'hFC, rd, er, ns);
      n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL below_base: got %h/%b exp 00000000/1", rd, er); end
      xfer(1, 1'b0, 4'h0, 32'h0, 32'h200, rd, er, ns);
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL above_top: got %b exp 1", er); end
      release_bus(1);
   endtask

   task automatic test_reset_in_wait;
      logic [31:0] rd; logic er; int ns;
      xfer(2, 1'b1, 4'hF, 32'h01020304, 32'h40, rd, er, ns);
      n_tests++; if (ns !== 3) begin n_fail++; $display("FAIL w2_stall: got %0d exp 3", ns); end
      @(negedge clk);
      cen[2] = 1'b1; wen[2] = 1'b1; ben[2] = 4'hF; wdata[2] = 32'h55AA55AA; addr[2] = 32'h40;
      @(negedge clk);
      rst2_n = 1'b0;
      #1;
      n_tests++; if (stall[2] !== 1'b1) begin n_fail++; $display("FAIL rstw_stall: got %b exp 1", stall[2]); end
      n_tests++; if (rdata[2] !== 32'h0) begin n_fail++; $display("FAIL rstw_rdata: got %h exp 00000000", rdata[2]); end
      wen[2] = 1'b0;
      @(negedge clk);
      rst2_n = 1'b1;
      ns = 0;
      #1;
      while (stall[2] === 1'b1 && ns < 40) begin
         ns++;
         @(negedge clk);
         #1;
      end
      n_tests++; if (ns !== 3) begin n_fail++; $display("FAIL rstw_fresh_stall: got %0d exp 3", ns); end
      n_tests++; if (rdata[2] !== 32'h01020304) begin n_fail++; $display("FAIL rstw_old_value: got %h exp 01020304", rdata[2]); end
      xfer(2, 1'b1, 4'hF, 32'h55AA55AA, 32'h40, rd, er, ns);
      xfer(2, 1'b0, 4'h0, 32'h0, 32'h40, rd, er, ns);
      n_tests++; if (rd !== 32'h55AA55AA) begin n_fail++; $display("FAIL rstw_reissued: got %h exp 55aa55aa", rd); end
      release_bus(2);
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd; logic er; int ns;
      logic [31:0] exp_v [4];
      int t [4];
      exp_v[0] = 32'h1000_0001; exp_v[1] = 32'h2000_0002;
      exp_v[2] = 32'h3000_0003; exp_v[3] = 32'h4000_0004;
      for (int i = 0; i < 4; i++) xfer(0, 1'b1, 4'hF, exp_v[i], 32'(i * 4), rd, er, ns);
      for (int i = 0; i < 4; i++) begin
         xfer(0, 1'b0, 4'h0, 32'h0, 32'(i * 4), rd, er, ns);
         t[i] = cyc;
         n_tests++; if (ns !== 1) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %0d exp 1", i, ns); end
         n_tests++; if (rd !== exp_v[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h exp %h", i, rd, exp_v[i]); end
      end
      for (int i = 1; i < 4; i++) begin
         n_tests++; if (t[i] - t[i-1] !== 2) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d exp 2", i, t[i] - t[i-1]); end
      end
      release_bus(0);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_out_of_range();
      test_wait_states();
      test_reset_in_wait();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
